instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 106 ++++++++++
 tb/tb_instr_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, loadable read-first IMEM and prefetch FIFO feeding decode over valid/ready.
// Build macro FETCH_PERF_CNT_EN adds saturating stall_cycles and flush_count counters.
module instr_fetch_unit #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fetch_en,
    input  logic                          imem_we,
    input  logic [ADDR_W-1:0]             imem_waddr,
    input  logic [DATA_W-1:0]             imem_wdata,
    input  logic                          redirect_valid,
    input  logic [ADDR_W-1:0]             redirect_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_instr,
    output logic [ADDR_W-1:0]             out_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]                   stall_cycles,
    output logic [7:0]                    flush_count
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] imem [2**ADDR_W];
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] pc, inflight_pc;
    logic              inflight;
    logic [DATA_W-1:0] fifo_instr [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              issue, push, pop;

    assign issue      = fetch_en && !redirect_valid && (count + CW'(inflight) < CW'(FIFO_DEPTH));
    assign push       = inflight && !redirect_valid;
    assign pop        = out_valid && out_ready && !redirect_valid;
    assign out_valid  = count != '0;
    assign out_instr  = out_valid ? fifo_instr[rd_ptr] : '0;
    assign out_pc     = out_valid ? fifo_pc[rd_ptr] : '0;
    assign fifo_count = count;

    // Loader writes and synchronous fetch read; NBA ordering makes same-address access read-first
    always_ff @(posedge clk) begin
        if (imem_we) imem[imem_waddr] <= imem_wdata;
        if (issue) rdata <= imem[pc];
    end

    // PC and in-flight tracking; a redirect discards any pending read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + 1'b1;
                inflight_pc <= pc;
            end
        end
    end

    // FIFO storage, written only when the in-flight read lands
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= rdata;
            fifo_pc[wr_ptr]    <= inflight_pc;
        end
    end

    // FIFO pointers and occupancy; redirect flushes everything including a held head
    always_ff @(posedge clk or posedge reset) begin
        if (reset || redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters for decode backpressure cycles and redirect flushes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
            if (redirect_valid && flush_count != '1) flush_count <= flush_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of stream, backpressure, redirect, wrap, reset, fetch_en, read-first and perf counters.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0;
    logic        imem_we = 1'b0;
    logic [4:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
    logic        redirect_valid = 1'b0;
    logic [4:0]  redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [4:0]  out_pc;
    logic [2:0]  fifo_count;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [7:0]  flush_count;
`endif
    int n_checks = 0;
    int n_fail = 0;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .fifo_count(fifo_count)
`ifdef FETCH_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input int k);
        return 32'(32'h1111_1111 * k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_head(input string tag, input int k);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_pc"}, 64'(out_pc), 64'(k));
        check({tag, "_instr"}, 64'(out_instr), 64'(instr_of(k)));
    endtask

    task automatic wait_count(input logic [2:0] n);
        for (int i = 0; i < 20 && fifo_count != n; i++) tick();
        check("wait_count", 64'(fifo_count), 64'(n));
    endtask

    task automatic do_redirect(input logic [4:0] target);
        redirect_valid = 1'b1;
        redirect_pc = target;
        tick();
        redirect_valid = 1'b0;
        check("redir_flush_valid", 64'(out_valid), 64'd0);
        check("redir_flush_count", 64'(fifo_count), 64'd0);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            imem_we = 1'b1;
            imem_waddr = 5'(k);
            imem_wdata = instr_of(k);
            tick();
        end
        imem_we = 1'b0;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);

        fetch_en = 1'b1;
        out_ready = 1'b1;
        reset = 1'b0;
        tick();
        check("stream_lat1", 64'(out_valid), 64'd0);
        tick();
        expect_head("stream0", 0);
        for (int k = 1; k < 8; k++) begin
            tick();
            expect_head("stream", k);
        end

        out_ready = 1'b0;
        do_redirect(5'h00);
        for (int i = 0; i < 10; i++) tick();
        check("bp_count", 64'(fifo_count), 64'd4);
        expect_head("bp_hold", 0);
        out_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            tick();
            expect_head("bp_drain", k);
        end

        out_ready = 1'b0;
        wait_count(3'd3);
        out_ready = 1'b1;
        do_redirect(5'h11);
        tick();
        check("redir_gap", 64'(out_valid), 64'd0);
        tick();
        expect_head("redir_tgt", 'h11);
        tick();
        expect_head("redir_next", 'h12);

        do_redirect(5'h1F);
        tick();
        tick();
        expect_head("wrap_1f", 'h1F);
        tick();
        expect_head("wrap_00", 0);
        tick();
        expect_head("wrap_01", 1);

        out_ready = 1'b0;
        wait_count(3'd3);
        reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_count", 64'(fifo_count), 64'd0);
        check("async_rst_pc", 64'(out_pc), 64'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        check("rst_restart_lat", 64'(out_valid), 64'd0);
        tick();
        expect_head("rst_restart", 0);

        out_ready = 1'b0;
        tick();
        check("fe_two_buf", 64'(fifo_count), 64'd2);
        fetch_en = 1'b0;
        tick();
        check("fe_inflight_lands", 64'(fifo_count), 64'd3);
        tick();
        check("fe_no_issue", 64'(fifo_count), 64'd3);
        out_ready = 1'b1;
        tick();
        expect_head("fe_drain1", 1);
        tick();
        expect_head("fe_drain2", 2);
        tick();
        check("fe_empty", 64'(out_valid), 64'd0);
        tick();
        check("fe_stays_empty", 64'(fifo_count), 64'd0);

        imem_we = 1'b1;
        imem_waddr = 5'd3;
        imem_wdata = 32'hDEAD_BEEF;
        fetch_en = 1'b1;
        tick();
        imem_we = 1'b0;
        tick();
        expect_head("read_first_old", 3);
        do_redirect(5'd3);
        tick();
        tick();
        check("read_first_new_pc", 64'(out_pc), 64'd3);
        check("read_first_new", 64'(out_instr), 64'hDEAD_BEEF);

`ifdef FETCH_PERF_CNT_EN
        reset = 1'b1;
        #1;
        check("perf_rst_stall", 64'(stall_cycles), 64'd0);
        check("perf_rst_flush", 64'(flush_count), 64'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 10; i++) tick();
        check("perf_stall", 64'(stall_cycles), 64'd10);
        out_ready = 1'b1;
        do_redirect(5'd0);
        check("perf_flush", 64'(flush_count), 64'd1);
        check("perf_stall_hold", 64'(stall_cycles), 64'd10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
